// File: rtl/mux_cfg_pkg.sv
// Shared types and sizing helpers for the routing-mux configuration loader.
package mux_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } cfg_state_e;

  localparam int DEF_NUM_MUX  = 8;
  localparam int DEF_SEL_BITS = 3;
  localparam int DEF_WORD_W   = 8;

  function automatic int cfg_words(input int total, input int word_w);
    return (total + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/mux_cfg_shadow_shreg.sv
// Word-wide shadow shift register: each loaded word enters at the bottom,
// so the first word of a frame ends up most significant.
module mux_cfg_shadow_shreg #(
  parameter int WORD_W = 8,
  parameter int WORDS  = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic [WORD_W-1:0]       data_i,
  output logic [WORDS*WORD_W-1:0] shadow_o
);

  localparam int SH_W = WORDS * WORD_W;

  logic [SH_W-1:0] shadow_q;
  logic [SH_W-1:0] shadow_d;
  logic [SH_W-1:0] shifted;

  generate
    if (WORDS == 1) begin : g_single
      assign shifted = data_i;
    end else begin : g_multi
      assign shifted = {shadow_q[SH_W-WORD_W-1:0], data_i};
    end
  endgenerate

  // Clear wins over load so a restart discards a word offered in the same cycle.
  always_comb begin
    shadow_d = shadow_q;
    if (clr_i) begin
      shadow_d = '0;
    end else if (load_i) begin
      shadow_d = shifted;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign shadow_o = shadow_q;

endmodule

// File: rtl/mux_cfg_frame_loader.sv
// Loads a configuration frame into a shadow register and commits it atomically
// to the active sram/sram_inv bundle feeding the routing tree muxes.
module mux_cfg_frame_loader
  import mux_cfg_pkg::*;
#(
  parameter int NUM_MUX  = DEF_NUM_MUX,
  parameter int SEL_BITS = DEF_SEL_BITS,
  parameter int WORD_W   = DEF_WORD_W
) (
  input  logic                         prog_clk,
  input  logic                         pReset,
  input  logic                         cfg_start,
  input  logic [WORD_W-1:0]            cfg_data,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic [NUM_MUX*SEL_BITS-1:0]  sram,
  output logic [NUM_MUX*SEL_BITS-1:0]  sram_inv,
  output logic                         cfg_done,
  output logic                         cfg_err
);

  localparam int TOTAL = NUM_MUX * SEL_BITS;
  localparam int WORDS = cfg_words(TOTAL, WORD_W);
  localparam int SH_W  = WORDS * WORD_W;
  localparam int CNT_W = $clog2(WORDS + 1);

  cfg_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TOTAL-1:0] sram_q, sram_d;
  logic [TOTAL-1:0] sram_inv_q, sram_inv_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             commit_q, commit_d;

  logic             restart;
  logic             accept;
  logic             last_word;
  logic [SH_W-1:0]  shadow;

  // A start pulse is honoured in every state except COMMIT.
  assign restart   = cfg_start && (state_q != COMMIT);
  assign accept    = (state_q == LOAD) && cfg_valid && !cfg_start;
  assign last_word = accept && (cnt_q == CNT_W'(WORDS - 1));

  mux_cfg_shadow_shreg #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_shadow (
    .clk_i    (prog_clk),
    .rst_i    (pReset),
    .clr_i    (restart),
    .load_i   (accept),
    .data_i   (cfg_data),
    .shadow_o (shadow)
  );

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cfg_start) state_d = LOAD;
      LOAD:    if (cfg_start) state_d = LOAD;
               else if (last_word) state_d = COMMIT;
      COMMIT:  state_d = DONE;
      DONE:    if (cfg_start) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state_q == LOAD);
  end

  // The commit is registered once more out of COMMIT, so the new bundle and
  // cfg_done appear two edges after the final word is accepted.
  always_comb begin
    cnt_d      = cnt_q;
    sram_d     = sram_q;
    sram_inv_d = sram_inv_q;
    done_d     = done_q;
    err_d      = err_q;
    commit_d   = (state_q == COMMIT);

    if (restart) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (commit_q) begin
      sram_d     = shadow[TOTAL-1:0];
      sram_inv_d = ~shadow[TOTAL-1:0];
      err_d      = 1'b0;
    end

    if (restart) begin
      done_d = 1'b0;
    end else if (commit_q) begin
      done_d = 1'b1;
    end

    if (cfg_start && (state_q == LOAD)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cnt_q      <= '0;
      sram_q     <= '0;
      sram_inv_q <= '1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      commit_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sram_q     <= sram_d;
      sram_inv_q <= sram_inv_d;
      done_q     <= done_d;
      err_q      <= err_d;
      commit_q   <= commit_d;
    end
  end

  assign sram     = sram_q;
  assign sram_inv = sram_inv_q;
  assign cfg_done = done_q;
  assign cfg_err  = err_q;

endmodule

// File: tb/tb_mux_cfg_frame_loader.sv
// Directed bench for mux_cfg_frame_loader: stimulus pushes expected commits into a
// scoreboard, a negedge monitor pops and compares on each cfg_done rise.
module tb_mux_cfg_frame_loader;

  logic        prog_clk  = 1'b0;
  logic        pReset    = 1'b1;
  logic        cfg_start = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [7:0]  cfg_data  = 8'h00;
  logic        cfg_ready;
  logic        cfg_done;
  logic        cfg_err;
  logic [23:0] sram;
  logic [23:0] sram_inv;

  int errors    = 0;
  int checks    = 0;
  int cyc       = 0;
  int ready_cnt = 0;
  int last_acc  = 0;

  typedef struct {
    logic [23:0] sram;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];

  mux_cfg_frame_loader dut (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .sram      (sram),
    .sram_inv  (sram_inv),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Monitor: a rising cfg_done is the DUT presenting a committed frame.
  logic done_prev = 1'b0;
  always @(negedge prog_clk) begin
    exp_t        e;
    logic [23:0] inv_exp;
    if (pReset) begin
      done_prev <= 1'b0;
    end else begin
      if (cfg_ready) ready_cnt <= ready_cnt + 1;
      if (cfg_done && !done_prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL commit_unexpected: sram=%h expected no commit", sram);
        end else begin
          e       = sb.pop_front();
          inv_exp = ~e.sram;
          check({e.name, "_sram"},     32'(sram),     32'(e.sram));
          check({e.name, "_sram_inv"}, 32'(sram_inv), 32'(inv_exp));
          check({e.name, "_err"},      32'(cfg_err),  32'd0);
          check({e.name, "_latency"},  32'(cyc),      32'(e.cyc));
        end
      end
      done_prev <= cfg_done;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge prog_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step(1);
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    int n  = 0;
    bit ok = 1'b0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    while (!ok && n < 20) begin
      @(negedge prog_clk);
      ok = cfg_ready;
      @(posedge prog_clk);
      #1;
      n++;
    end
    cfg_valid = 1'b0;
    last_acc  = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: word %h not accepted within 20 cycles", d);
    end
  endtask

  task automatic expect_commit(input logic [23:0] v, input string name);
    sb.push_back('{sram: v, cyc: last_acc + 2, name: name});
  endtask

  task automatic wait_commit(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step(1);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d commits pending, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int r0;

    // Reset release, no activity
    step(3);
    pReset = 1'b0;
    step(2);
    check("rst_sram",     32'(sram),      32'h000000);
    check("rst_sram_inv", 32'(sram_inv),  32'hFFFFFF);
    check("rst_ready",    32'(cfg_ready), 32'd0);
    check("rst_done",     32'(cfg_done),  32'd0);
    check("rst_err",      32'(cfg_err),   32'd0);

    // Back-to-back frame
    r0 = ready_cnt;
    pulse_start();
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hF0);
    expect_commit(24'hA53CF0, "b2b");
    wait_commit("b2b");
    check("b2b_ready_cycles", 32'(ready_cnt - r0), 32'd3);
    check("b2b_done",         32'(cfg_done),       32'd1);
    check("b2b_mux0",         32'(sram[2:0]),      32'd0);
    check("b2b_mux7",         32'(sram[23:21]),    32'd5);

    // Same frame with gaps between words
    pulse_start();
    check("gap_done_cleared", 32'(cfg_done), 32'd0);
    send_word(8'hA5);
    step(1);
    send_word(8'h3C);
    step(1);
    check("gap_sram_hold", 32'(sram), 32'hA53CF0);
    send_word(8'hF0);
    expect_commit(24'hA53CF0, "gap");
    wait_commit("gap");

    // Abort mid-load
    pulse_start();
    send_word(8'h11);
    send_word(8'h11);
    send_word(8'h11);
    expect_commit(24'h111111, "base");
    wait_commit("base");
    pulse_start();
    send_word(8'hFF);
    check("abort_err_before", 32'(cfg_err), 32'd0);
    pulse_start();
    check("abort_err_set",    32'(cfg_err), 32'd1);
    check("abort_sram_hold1", 32'(sram),    32'h111111);
    send_word(8'h12);
    send_word(8'h34);
    check("abort_sram_hold2", 32'(sram),    32'h111111);
    send_word(8'h56);
    expect_commit(24'h123456, "abort");
    step(1);
    check("abort_sram_hold3", 32'(sram),     32'h111111);
    check("abort_done_late",  32'(cfg_done), 32'd0);
    check("abort_err_held",   32'(cfg_err),  32'd1);
    wait_commit("abort");
    check("abort_err_clear",  32'(cfg_err),  32'd0);

    // Asynchronous reset mid-load
    pulse_start();
    send_word(8'h01);
    send_word(8'h02);
    #1;
    pReset = 1'b1;
    #1;
    check("arst_sram",     32'(sram),      32'h000000);
    check("arst_sram_inv", 32'(sram_inv),  32'hFFFFFF);
    check("arst_done",     32'(cfg_done),  32'd0);
    check("arst_err",      32'(cfg_err),   32'd0);
    check("arst_ready",    32'(cfg_ready), 32'd0);
    @(posedge prog_clk);
    #1;
    pReset = 1'b0;
    step(1);
    pulse_start();
    send_word(8'hDE);
    send_word(8'hAD);
    send_word(8'h42);
    expect_commit(24'hDEAD42, "post_rst");
    wait_commit("post_rst");

    // Stray cfg_valid in DONE
    cfg_data  = 8'h77;
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      check("done_valid_ready", 32'(cfg_ready), 32'd0);
      @(posedge prog_clk);
      #1;
    end
    cfg_valid = 1'b0;
    check("done_valid_sram", 32'(sram),     32'hDEAD42);
    check("done_valid_done", 32'(cfg_done), 32'd1);
    check("done_valid_err",  32'(cfg_err),  32'd0);

    // Stray cfg_valid in IDLE
    pReset = 1'b1;
    step(1);
    pReset = 1'b0;
    step(1);
    cfg_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge prog_clk);
      check("idle_valid_ready", 32'(cfg_ready), 32'd0);
      @(posedge prog_clk);
      #1;
    end
    cfg_valid = 1'b0;
    step(2);
    check("idle_valid_sram",     32'(sram),     32'h000000);
    check("idle_valid_sram_inv", 32'(sram_inv), 32'hFFFFFF);
    check("idle_valid_done",     32'(cfg_done), 32'd0);
    check("idle_valid_err",      32'(cfg_err),  32'd0);
    check("sb_drained",          32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded 100000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
